mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers.
// Each operation is one shift-add or restoring-division step per clock.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic                 sgn;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       madd, rem_sh, diff;
  logic [2*WIDTH-1:0]   mult_next, div_next, prod;
  logic [WIDTH-1:0]     quo, rem;

  assign sgn   = ~op[0];
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  // acc = {partial product, remaining multiplier bits}; carry shifts back in
  assign madd      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mult_next = {madd, acc_q[WIDTH-1:1]};

  // acc = {remainder, dividend bits shifting into quotient}
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opnd_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d   = op[1];
          neg_res_d  = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = sgn && a[WIDTH-1];
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          cnt_d      = '0;
          dz_d       = op[1] && (b == '0);
          div_zero_d = 1'b0;
          state_d    = (op[1] && (b == '0)) ? FINISH : (op[1] ? DIV : MULT);
        end else begin
          if (hi_wr) hi_d = wdata;
          if (lo_wr) lo_d = wdata;
        end
      end
      MULT, DIV: begin
        acc_d = (state_q == MULT) ? mult_next : div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule
